// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the sequential Booth multiplier:
//   state_e     - multiplier FSM encoding (IDLE, RUN, DONE)
//   booth_op_e  - per-step operation picked from {Qr[0], q_1}
//   cla4()      - one 4-bit carry-lookahead slice used by booth_addsub
// -----------------------------------------------------------------------------
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2
  } booth_op_e;

  // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}.
  // All carries are formed directly from generate/propagate terms and the
  // slice carry-in, so no ripple exists inside the slice.
  function automatic logic [4:0] cla4(input logic [3:0] a,
                                      input logic [3:0] b,
                                      input logic       cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/booth_addsub.sv
// -----------------------------------------------------------------------------
// booth_addsub
// Combinational N-bit adder/subtractor built from 4-bit CLA slices.
// The operand width is padded up to a multiple of 4; padding bits are zero
// and their sum bits are discarded.
//   a    in  N  first operand
//   b    in  N  second operand
//   sub  in  1  0: y = a + b, 1: y = a - b (a + ~b + 1)
//   y    out N  result, modulo 2^N
// -----------------------------------------------------------------------------
module booth_addsub #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic [N-1:0] y
);
  import booth_pkg::*;

  localparam int NSL = (N + 3) / 4;

  // Slices are chained in one process so the carry between slices is a
  // local variable rather than a looped net.
  always_comb begin
    logic       carry;
    logic [3:0] a4;
    logic [3:0] b4;
    logic [4:0] r;
    // NOTE: every variable written here gets a value before any branch, so
    // no path can leave it holding its old value (which would infer a latch).
    y     = '0;
    a4    = '0;
    b4    = '0;
    r     = '0;
    carry = sub;  // subtraction: carry-in of 1 completes the two's complement
    for (int s = 0; s < NSL; s++) begin
      for (int j = 0; j < 4; j++) begin
        if (4 * s + j < N) begin
          a4[j] = a[4*s+j];
          b4[j] = b[4*s+j] ^ sub;
        end else begin
          a4[j] = 1'b0;
          b4[j] = 1'b0;
        end
      end
      r = cla4(a4, b4, carry);
      for (int j = 0; j < 4; j++) begin
        if (4 * s + j < N) begin
          y[4*s+j] = r[j];
        end
      end
      carry = r[4];
    end
  end

endmodule

// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or
// unsigned per operation. One Booth step per clock; WIDTH+1 steps per
// operation; start/busy/done handshake with back-to-back issue from DONE.
//   clk           in  1        rising-edge clock
//   rst           in  1        synchronous active-high reset (highest priority)
//   start         in  1        request, sampled only while not busy
//   signed_mode   in  1        1: two's-complement operands, 0: unsigned
//   multiplicand  in  WIDTH    M operand, captured with start
//   multiplier    in  WIDTH    Q operand, captured with start
//   busy          out 1        high while iterating (RUN)
//   done          out 1        one-cycle pulse, product valid
//   product       out 2*WIDTH  result, held until the next result or rst
// -----------------------------------------------------------------------------
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  import booth_pkg::*;

  localparam int CNT_W = $clog2(WIDTH + 2);
  // One extra datapath bit lets the same signed engine handle unsigned
  // operands (extension bit 0) and keeps A - M from overflowing when M is
  // the most negative WIDTH-bit value.
  localparam int DW = WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_e                 state_q, state_d;
  logic [DW-1:0]          a_q, a_d;
  logic [DW-1:0]          qr_q, qr_d;
  logic [DW-1:0]          mr_q, mr_d;
  logic                   q1_q, q1_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     product_q, product_d;

  booth_op_e              op;
  logic                   do_sub;
  logic [DW-1:0]          addsub_y;
  logic [DW-1:0]          a_step;
  logic [DW-1:0]          a_sh;
  logic [DW-1:0]          qr_sh;
  logic                   m_ext;
  logic                   q_ext;

  // Booth recoding of the current multiplier bit pair {Qr[0], q_1}.
  always_comb begin
    unique case ({qr_q[0], q1_q})
      2'b01:   op = ADD;
      2'b10:   op = SUB;
      default: op = NOP;
    endcase
  end

  assign do_sub = (op == SUB);

  booth_addsub #(
    .N (DW)
  ) u_addsub (
    .a   (a_q),
    .b   (mr_q),
    .sub (do_sub),
    .y   (addsub_y)
  );

  assign a_step = (op == NOP) ? a_q : addsub_y;

  // Arithmetic right shift of {A, Qr, q_1}: A's MSB is replicated, A's LSB
  // moves into Qr, and Qr's LSB becomes the next q_1.
  assign a_sh  = {a_step[DW-1], a_step[DW-1:1]};
  assign qr_sh = {a_step[0], qr_q[DW-1:1]};

  assign m_ext = signed_mode & multiplicand[WIDTH-1];
  assign q_ext = signed_mode & multiplier[WIDTH-1];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    qr_d      = qr_q;
    mr_d      = mr_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          mr_d    = {m_ext, multiplicand};
          qr_d    = {q_ext, multiplier};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_sh;
        qr_d  = qr_sh;
        q1_d  = qr_q[0];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          // The full product fits in 2*WIDTH bits, so the top two bits of
          // {A, Qr} are pure sign/zero extension and are dropped.
          product_d = {a_sh[DW-3:0], qr_sh};
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      qr_q      <= '0;
      mr_q      <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      qr_q      <= qr_d;
      mr_q      <= mr_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Bench for booth_mult_seq at WIDTH=8 (directed vectors, handshake, reset
// abort, back-to-back) and at WIDTH=16 / WIDTH=5 (operands from $urandom
// against an arithmetic reference product). Inputs are driven and outputs
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  mc8, mp8;
  logic [15:0] prod8;

  logic        start16, sm16, busy16, done16;
  logic [15:0] mc16, mp16;
  logic [31:0] prod16;

  logic        start5, sm5, busy5, done5;
  logic [4:0]  mc5, mp5;
  logic [9:0]  prod5;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(mc8), .multiplier(mp8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  booth_mult_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplicand(mc16), .multiplier(mp16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  booth_mult_seq #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .signed_mode(sm5),
    .multiplicand(mc5), .multiplier(mp5),
    .busy(busy5), .done(done5), .product(prod5)
  );

  // One WIDTH=8 operation. lat counts falling edges after the start request:
  // the first one follows the accepting edge, so done should appear at 10.
  task automatic do_op8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat,
                        output logic busy_first);
    @(negedge clk);
    start8 = 1'b1; sm8 = sm; mc8 = a; mp8 = b;
    @(negedge clk);
    start8 = 1'b0; sm8 = ~sm; mc8 = ~a; mp8 = ~b;
    lat = 1;
    busy_first = busy8;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = prod8;
  endtask

  task automatic do_op16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat);
    @(negedge clk);
    start16 = 1'b1; sm16 = sm; mc16 = a; mp16 = b;
    @(negedge clk);
    start16 = 1'b0; mc16 = ~a; mp16 = ~b;
    lat = 1;
    while (!done16 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    p = prod16;
  endtask

  task automatic do_op5(input logic sm, input logic [4:0] a, input logic [4:0] b,
                        output logic [9:0] p, output int lat);
    @(negedge clk);
    start5 = 1'b1; sm5 = sm; mc5 = a; mp5 = b;
    @(negedge clk);
    start5 = 1'b0; mc5 = ~a; mp5 = ~b;
    lat = 1;
    while (!done5 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    p = prod5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0)    begin n_err++; $display("FAIL reset busy8: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0)    begin n_err++; $display("FAIL reset done8: got %b expected 0", done8); end
    n_cmp++; if (prod8 !== 16'h0)   begin n_err++; $display("FAIL reset prod8: got %h expected 0000", prod8); end
    n_cmp++; if (busy16 !== 1'b0)   begin n_err++; $display("FAIL reset busy16: got %b expected 0", busy16); end
    n_cmp++; if (done16 !== 1'b0)   begin n_err++; $display("FAIL reset done16: got %b expected 0", done16); end
    n_cmp++; if (prod16 !== 32'h0)  begin n_err++; $display("FAIL reset prod16: got %h expected 00000000", prod16); end
    n_cmp++; if (prod5 !== 10'h0)   begin n_err++; $display("FAIL reset prod5: got %h expected 000", prod5); end
    rst = 1'b0;
  endtask

  task automatic test_directed8();
    // sign mode, multiplicand, multiplier, hand-computed 16-bit product
    logic        vs [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  va [9] = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'hFB, 8'h80, 8'h80, 8'hFF};
    logic [7:0]  vb [9] = '{8'h80, 8'hFF, 8'hFF, 8'hC8, 8'h80, 8'h03, 8'h02, 8'h02, 8'hFF};
    logic [15:0] ve [9] = '{16'h4000, 16'hFF81, 16'hFE01, 16'h0000, 16'hFF80,
                            16'hFFF1, 16'h0100, 16'hFF00, 16'h0001};
    logic [15:0] p;
    int          lat;
    logic        bf;
    for (int i = 0; i < 9; i++) begin
      do_op8(vs[i], va[i], vb[i], p, lat, bf);
      n_cmp++; if (p !== ve[i]) begin
        n_err++; $display("FAIL directed%0d product (%h x %h, signed=%b): got %h expected %h",
                          i, va[i], vb[i], vs[i], p, ve[i]);
      end
      n_cmp++; if (lat != 10) begin
        n_err++; $display("FAIL directed%0d latency: got %0d expected 10", i, lat);
      end
      n_cmp++; if (bf !== 1'b1) begin
        n_err++; $display("FAIL directed%0d busy after accept: got %b expected 1", i, bf);
      end
      n_cmp++; if (busy8 !== 1'b0) begin
        n_err++; $display("FAIL directed%0d busy in done cycle: got %b expected 0", i, busy8);
      end
    end
    // done must be a single-cycle pulse
    @(negedge clk);
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL done pulse width: got %b expected 0", done8); end
    n_cmp++; if (prod8 !== 16'h0001) begin n_err++; $display("FAIL product hold after done: got %h expected 0001", prod8); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // Op 1: signed 12 x -11 = -132. start stays high and operands wander
    // throughout RUN; none of it may disturb the captured operation.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; mc8 = 8'd12; mp8 = 8'hF5;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done8) break;
      mc8 = 8'(lat * 17);
      mp8 = ~mc8;
      sm8 = ~sm8;
    end
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL b2b first latency: got %0d expected 10", lat); end
    n_cmp++; if (prod8 !== 16'hFF7C) begin n_err++; $display("FAIL b2b first product: got %h expected ff7c", prod8); end
    // Op 2 captured from DONE: unsigned 200 x 3 = 600.
    sm8 = 1'b0; mc8 = 8'd200; mp8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0; mc8 = 8'h00; mp8 = 8'h00;
    lat = 1;
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL b2b second accept busy: got %b expected 1", busy8); end
    n_cmp++; if (prod8 !== 16'hFF7C) begin n_err++; $display("FAIL b2b product held during run: got %h expected ff7c", prod8); end
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL b2b done-to-done spacing: got %0d expected 10", lat); end
    n_cmp++; if (prod8 !== 16'h0258) begin n_err++; $display("FAIL b2b second product: got %h expected 0258", prod8); end
  endtask

  task automatic test_reset_abort();
    logic [15:0] p;
    int          lat;
    logic        bf;
    logic        saw_done;
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b1; mc8 = 8'd7; mp8 = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL abort busy: got %b expected 0", busy8); end
    n_cmp++; if (done8 !== 1'b0) begin n_err++; $display("FAIL abort done: got %b expected 0", done8); end
    n_cmp++; if (prod8 !== 16'h0000) begin n_err++; $display("FAIL abort product: got %h expected 0000", prod8); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done8 !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort spurious done: got %b expected 0", saw_done); end
    do_op8(1'b0, 8'h0F, 8'h11, p, lat, bf);
    n_cmp++; if (p !== 16'h00FF) begin n_err++; $display("FAIL post-abort product: got %h expected 00ff", p); end
    n_cmp++; if (lat != 10) begin n_err++; $display("FAIL post-abort latency: got %0d expected 10", lat); end
  endtask

  task automatic test_random16();
    logic [15:0] a, b;
    logic [31:0] p, e;
    longint      full;
    logic        sm;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      a  = (i == 0) ? 16'h8000 : 16'($urandom);
      b  = (i == 0) ? 16'h8000 : 16'($urandom);
      sm = i[0];
      if (sm) full = longint'($signed(a)) * longint'($signed(b));
      else    full = longint'(a) * longint'(b);
      e = full[31:0];
      do_op16(sm, a, b, p, lat);
      n_cmp++; if (p !== e) begin
        n_err++; $display("FAIL w16 product (%h x %h, signed=%b): got %h expected %h", a, b, sm, p, e);
      end
      n_cmp++; if (lat != 18) begin
        n_err++; $display("FAIL w16 latency: got %0d expected 18", lat);
      end
    end
  endtask

  task automatic test_random5();
    logic [4:0] a, b;
    logic [9:0] p, e;
    longint     full;
    logic       sm;
    int         lat;
    for (int i = 0; i < 300; i++) begin
      a  = (i < 2) ? 5'h10 : 5'($urandom);
      b  = (i < 2) ? 5'h1F : 5'($urandom);
      sm = i[0];
      if (sm) full = longint'($signed(a)) * longint'($signed(b));
      else    full = longint'(a) * longint'(b);
      e = full[9:0];
      do_op5(sm, a, b, p, lat);
      n_cmp++; if (p !== e) begin
        n_err++; $display("FAIL w5 product (%h x %h, signed=%b): got %h expected %h", a, b, sm, p, e);
      end
      n_cmp++; if (lat != 7) begin
        n_err++; $display("FAIL w5 latency: got %0d expected 7", lat);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    start8  = 1'b0; sm8  = 1'b0; mc8  = '0; mp8  = '0;
    start16 = 1'b0; sm16 = 1'b0; mc16 = '0; mp16 = '0;
    start5  = 1'b0; sm5  = 1'b0; mc5  = '0; mp5  = '0;
    test_reset();
    test_directed8();
    test_back_to_back();
    test_reset_abort();
    test_random16();
    test_random5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
